// File: rtl/gaussian_blur.sv
// Streaming 3x3 Gaussian blur between two FWFT FIFOs; raster-order in, raster-order out.
// Borders are forced to zero and a flush phase drains the window at frame end.
module gaussian_blur #(
    parameter int unsigned WIDTH  = 720,
    parameter int unsigned HEIGHT = 540
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       in_empty,
    output logic       in_rd_en,
    input  logic [7:0] in_dout,
    input  logic       out_full,
    output logic       out_wr_en,
    output logic [7:0] out_din
);
    localparam int unsigned NPIX  = WIDTH * HEIGHT;
    localparam int unsigned CNT_W = $clog2(NPIX + 1);
    localparam int unsigned COL_W = $clog2(WIDTH);
    localparam int unsigned ROW_W = $clog2(HEIGHT);
    localparam int unsigned WIN   = 2 * WIDTH + 2;

    typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   in_cnt, out_cnt;
    logic [COL_W-1:0]   out_col;
    logic [ROW_W-1:0]   out_row;
    logic               valid;
    logic [7:0]         data;
    logic [7:0]         win [WIN];
    logic               can_move, step, load, frame_done;
    logic [7:0]         new_pix;
    logic [11:0]        sum;
    logic               border;
    logic [7:0]         blurred;

    function automatic logic [11:0] tap(input logic [7:0] p);
        return 12'(p);
    endfunction

    // Next-state and handshake control
    always_comb begin
        state_next = state;
        in_rd_en   = 1'b0;
        step       = 1'b0;
        load       = 1'b0;
        frame_done = 1'b0;
        out_wr_en  = valid & ~out_full & ~reset;
        can_move   = ~valid | out_wr_en;
        unique case (state)
            FILL: begin
                if (!in_empty && can_move && !reset) begin
                    in_rd_en = 1'b1;
                    step     = 1'b1;
                    if (in_cnt == CNT_W'(WIDTH)) state_next = RUN;
                end
            end
            RUN: begin
                if (!in_empty && can_move && !reset) begin
                    in_rd_en = 1'b1;
                    step     = 1'b1;
                    load     = 1'b1;
                    if (in_cnt == CNT_W'(NPIX - 1)) state_next = FLUSH;
                end
            end
            FLUSH: begin
                if (can_move && !reset) begin
                    step = 1'b1;
                    load = 1'b1;
                    if (out_cnt == CNT_W'(NPIX - 1)) begin
                        frame_done = 1'b1;
                        state_next = FILL;
                    end
                end
            end
            default: state_next = FILL;
        endcase
    end

    // Kernel: the incoming pixel is the bottom-right tap, so results load on the accepting edge
    always_comb begin
        new_pix = (state == FLUSH) ? 8'd0 : in_dout;
        sum = tap(win[2*WIDTH+1]) + (tap(win[2*WIDTH]) << 1) + tap(win[2*WIDTH-1])
            + (tap(win[WIDTH+1]) << 1) + (tap(win[WIDTH]) << 2) + (tap(win[WIDTH-1]) << 1)
            + tap(win[1]) + (tap(win[0]) << 1) + tap(new_pix);
        border = (out_row == '0) || (out_row == ROW_W'(HEIGHT - 1)) ||
                 (out_col == '0) || (out_col == COL_W'(WIDTH - 1));
        blurred = border ? 8'd0 : 8'(sum >> 4);
    end

    always_ff @(posedge clock) begin
        if (reset) state <= FILL;
        else       state <= state_next;
    end

    // Counters and one-entry output register
    always_ff @(posedge clock) begin
        if (reset) begin
            in_cnt  <= '0;
            out_cnt <= '0;
            out_col <= '0;
            out_row <= '0;
            valid   <= 1'b0;
            data    <= 8'd0;
        end else begin
            if (in_rd_en) in_cnt <= in_cnt + CNT_W'(1);
            if (load) begin
                out_cnt <= out_cnt + CNT_W'(1);
                if (out_col == COL_W'(WIDTH - 1)) begin
                    out_col <= '0;
                    out_row <= out_row + ROW_W'(1);
                end else begin
                    out_col <= out_col + COL_W'(1);
                end
            end
            if (frame_done) begin
                in_cnt  <= '0;
                out_cnt <= '0;
                out_col <= '0;
                out_row <= '0;
            end
            if (load) begin
                valid <= 1'b1;
                data  <= blurred;
            end else if (out_wr_en) begin
                valid <= 1'b0;
            end
        end
    end

    // Two line buffers plus row taps; contents survive reset harmlessly
    always_ff @(posedge clock) begin
        if (step) begin
            win[0] <= new_pix;
            for (int i = 1; i < int'(WIN); i++) win[i] <= win[i-1];
        end
    end

    assign out_din = data;
endmodule

// File: doc/gaussian_blur.md
GAUSSIAN_BLUR -- requirements
Module: gaussian_blur

Interface
REQ-001 SHALL have parameter WIDTH, default 720, image width in pixels (>= 4).
REQ-002 SHALL have parameter HEIGHT, default 540, image height in pixels (>= 3).
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_empty  input  1  upstream grayscale FIFO empty flag.
REQ-006 SHALL have port in_rd_en  output  1  upstream FIFO pop; in_dout is valid while in_empty=0 (first-word-fall-through).
REQ-007 SHALL have port in_dout  input  8  grayscale pixel, raster order, row 0 first.
REQ-008 SHALL have port out_full  input  1  downstream (Sobel-stage) FIFO full flag.
REQ-009 SHALL have port out_wr_en  output  1  downstream FIFO push.
REQ-010 SHALL have port out_din  output  8  blurred pixel.

Function
REQ-011 SHALL apply the 3x3 kernel [1 2 1; 2 4 2; 1 2 1] to each centre pixel (r,c), sum in 12 bits unsigned (max 4080, no overflow), and output sum[11:4] (truncation, no rounding).
REQ-012 SHALL output 0 for border centres: r=0, r=HEIGHT-1, c=0, or c=WIDTH-1.
REQ-013 SHALL emit exactly WIDTH*HEIGHT output pixels per frame, in raster order, one per input pixel.
REQ-014 SHALL hold a shift window of 2*WIDTH+3 pixels (two line buffers plus 3-tap row), shifting by one on every input accept or flush step.
REQ-015 SHALL hold a one-entry output register (valid, data); out_wr_en = valid AND NOT out_full (combinational); valid clears on a write unless reloaded in the same cycle.
REQ-016 SHALL accept input (in_rd_en=1) only when in_empty=0 AND state is FILL or RUN AND (valid=0 OR out_wr_en=1); in_rd_en SHALL never assert while in_empty=1.
REQ-017 SHALL implement states FILL, RUN, FLUSH with an input counter (0..WIDTH*HEIGHT) and an output counter (0..WIDTH*HEIGHT).
REQ-018 FILL: accepts the first WIDTH+1 pixels of a frame with no output load; after the (WIDTH+1)th accept SHALL go to RUN.
REQ-019 RUN: each accept SHALL load the output register on the same edge with the result for centre index (accept_count-WIDTH-1); after the last (WIDTH*HEIGHT-th) input accept SHALL go to FLUSH.
REQ-020 FLUSH: SHALL shift a zero into the window and load one output per step, stepping only when valid=0 OR out_wr_en=1, for WIDTH+1 steps; in_rd_en=0 throughout.
REQ-021 After the last output of a frame is written (output counter = WIDTH*HEIGHT), SHALL clear both counters and return to FILL; window contents need not be cleared.
REQ-022 Latency: output for centre (r,c) SHALL be loaded on the edge accepting pixel (r+1,c+1) (or the matching flush step) and written in the following cycle if out_full=0.
REQ-023 out_full held high SHALL stall the output register and, through REQ-016, the input; no pixel SHALL be dropped or duplicated.
REQ-024 in_empty gaps SHALL stall without changing window, counters, or state.
REQ-025 Border zeroing SHALL be decided from the output counter's row/column (column/row counters, not division), so zeros injected by FLUSH never affect interior results.

Reset
REQ-026 While reset=1 at a rising edge: state=FILL, counters=0, valid=0; out_wr_en=0, in_rd_en=0, out_din=0 in the following cycle.
REQ-027 Reset mid-frame SHALL abandon the partial frame; the next accepted pixel after reset deasserts is treated as pixel (0,0).

Verification (WIDTH=8, HEIGHT=6 unless stated)
REQ-028 Constant image 100, FIFOs never stalled -> 48 outputs; 24 interior = 100, 24 border = 0; in_rd_en pulses = 48.
REQ-029 Impulse 255 at (2,3), rest 0 -> (2,3)=63, (1,3)/(3,3)/(2,2)/(2,4)=31, diagonals (1,2),(1,4),(3,2),(3,4)=15, all others 0.
REQ-030 Ramp image pixel=r*8+c, out_full asserted every other cycle and in_empty random 30% -> output stream identical to unstalled run; in_rd_en never high when in_empty=1; out_wr_en never high when out_full=1.
REQ-031 Reset asserted after 20 accepts, then full constant-100 frame -> exactly 48 outputs, matching REQ-028.
REQ-032 Two back-to-back frames (constant 50 then constant 200) -> 96 outputs; interiors 50 then 200, borders 0, no stall cycles beyond FLUSH's WIDTH+1 steps.
REQ-033 Default parameters, uniform 255 image -> 388800 outputs; interior = 255 (4080>>4), border = 0.
